// File: rtl/serial_adder_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_subtractor_pkg
// Shared definitions for the serial adder/subtractor:
//   - DEFAULT_ADDER_WIDTH / DEFAULT_CHUNK_WIDTH : default parameter values
//   - state_e   : control FSM state encoding (IDLE / BUSY / DONE)
//   - idx_width : width of the chunk index counter for a given chunk count
// -----------------------------------------------------------------------------
package serial_adder_subtractor_pkg;

  localparam int DEFAULT_ADDER_WIDTH = 32;
  localparam int DEFAULT_CHUNK_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int idx_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_subtractor_if.sv
// -----------------------------------------------------------------------------
// serial_adder_subtractor_if
// Operand/result handshake bundle for serial_adder_subtractor.
//   in_valid/in_ready  : operand handshake (A, B, sub)
//   out_valid/out_ready: result handshake (sum, cout, overflow, zero)
//   busy               : block is not idle
// Modports: master = operand producer / result consumer, slave = the adder.
// -----------------------------------------------------------------------------
interface serial_adder_subtractor_if
  import serial_adder_subtractor_pkg::*;
#(
  parameter int ADDER_WIDTH = DEFAULT_ADDER_WIDTH
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [ADDER_WIDTH-1:0] A;
  logic [ADDER_WIDTH-1:0] B;
  logic                   sub;
  logic                   out_valid;
  logic                   out_ready;
  logic [ADDER_WIDTH-1:0] sum;
  logic                   cout;
  logic                   overflow;
  logic                   zero;
  logic                   busy;

  modport master (
    output in_valid, A, B, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, zero, busy
  );

  modport slave (
    input  in_valid, A, B, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow, zero, busy
  );

endinterface

// File: rtl/serial_adder_subtractor_chunk_adder.sv
// -----------------------------------------------------------------------------
// chunk_adder
// Purely combinational CHUNK_WIDTH-bit adder with carry in/out.
//   a, b : chunk operands
//   cin  : carry in
//   s    : chunk sum
//   cout : carry out of the chunk MSB
// -----------------------------------------------------------------------------
module chunk_adder
  import serial_adder_subtractor_pkg::*;
#(
  parameter int CHUNK_WIDTH = DEFAULT_CHUNK_WIDTH
) (
  input  logic [CHUNK_WIDTH-1:0] a,
  input  logic [CHUNK_WIDTH-1:0] b,
  input  logic                   cin,
  output logic [CHUNK_WIDTH-1:0] s,
  output logic                   cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK_WIDTH{1'b0}}, cin};

endmodule

// File: rtl/serial_adder_subtractor.sv
// -----------------------------------------------------------------------------
// serial_adder_subtractor
// Multi-cycle adder/subtractor computing CHUNK_WIDTH bits per cycle through a
// single reused chunk_adder. Result = A + (B ^ {sub}) + sub, so sub=1 gives
// A - B. Latency from acceptance to out_valid is ADDER_WIDTH/CHUNK_WIDTH cycles.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (aborts any operation)
//   bus  : serial_adder_subtractor_if.slave (handshakes, operands, result)
// Parameters: ADDER_WIDTH (operand width), CHUNK_WIDTH (must divide
// ADDER_WIDTH).
// Build option: define ADD_SUB_FLAGS_EN to produce registered cout, overflow
// and zero; otherwise those outputs are tied low.
// -----------------------------------------------------------------------------
module serial_adder_subtractor
  import serial_adder_subtractor_pkg::*;
#(
  parameter int ADDER_WIDTH = DEFAULT_ADDER_WIDTH,
  parameter int CHUNK_WIDTH = DEFAULT_CHUNK_WIDTH
) (
  input logic                     clk,
  input logic                     rst,
  serial_adder_subtractor_if.slave bus
);

  localparam int NCHUNK = ADDER_WIDTH / CHUNK_WIDTH;
  localparam int IDX_W  = idx_width(NCHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   carry_q, carry_d;
  logic [ADDER_WIDTH-1:0] a_q, a_d;
  logic [ADDER_WIDTH-1:0] b_q, b_d;    // B already conditioned by sub
  logic [ADDER_WIDTH-1:0] sum_q, sum_d;

  logic [CHUNK_WIDTH-1:0] chunk_a, chunk_b, chunk_s;
  logic                   chunk_cout;
  logic                   last_chunk;

  assign chunk_a    = a_q[int'(idx_q) * CHUNK_WIDTH +: CHUNK_WIDTH];
  assign chunk_b    = b_q[int'(idx_q) * CHUNK_WIDTH +: CHUNK_WIDTH];
  assign last_chunk = (idx_q == LAST_IDX);

  chunk_adder #(
    .CHUNK_WIDTH(CHUNK_WIDTH)
  ) u_chunk_adder (
    .a    (chunk_a),
    .b    (chunk_b),
    .cin  (carry_q),
    .s    (chunk_s),
    .cout (chunk_cout)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.A;
          b_d     = bus.B ^ {ADDER_WIDTH{bus.sub}};
          carry_d = bus.sub;
          idx_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        sum_d[int'(idx_q) * CHUNK_WIDTH +: CHUNK_WIDTH] = chunk_s;
        carry_d = chunk_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (last_chunk) begin
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
    end
  end

  // NOTE: operand registers carry no reset; they are always reloaded on
  // acceptance before being read, so resetting them would only cost area.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

`ifdef ADD_SUB_FLAGS_EN
  logic cout_q, cout_d;
  logic ovf_q, ovf_d;
  logic zero_q, zero_d;

  // Flags are captured on the final chunk, when sum_d holds the full result.
  always_comb begin
    cout_d = cout_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if (state_q == ST_BUSY && last_chunk) begin
      cout_d = chunk_cout;
      ovf_d  = (a_q[ADDER_WIDTH-1] == b_q[ADDER_WIDTH-1]) &&
               (chunk_s[CHUNK_WIDTH-1] != a_q[ADDER_WIDTH-1]);
      zero_d = (sum_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;
`else
  assign bus.cout     = 1'b0;
  assign bus.overflow = 1'b0;
  assign bus.zero     = 1'b0;
`endif

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.sum       = sum_q;

endmodule
